msg_buffer: RTL and testbench

MSG_BUFFER -- requirements
Module: msg_buffer

---
 rtl/msg_buffer.sv | 94 +++++++++
 tb/tb_msg_buffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/msg_buffer.sv
// Message FIFO between msg_parser and its consumer: first-word-fall-through, drops on full.
// Optional MSG_BUFFER_STATS_EN adds saturating drop_count / err_count outputs.
module msg_buffer #(
    parameter int MAX_MSG_BYTES = 32,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_msg_valid,
    input  logic [15:0]                in_msg_length,
    input  logic [MAX_MSG_BYTES*8-1:0] in_msg_data,
    input  logic                       in_msg_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_length,
    output logic [MAX_MSG_BYTES*8-1:0] out_data,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
`ifdef MSG_BUFFER_STATS_EN
    ,
    output logic [15:0]                drop_count,
    output logic [15:0]                err_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = MAX_MSG_BYTES * 8;

    logic [15:0]   mem_len  [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;

    logic          len_ok, good, bad, pop, wr, drop;
    logic [DW-1:0] masked_data;

    assign len_ok = (in_msg_length != 16'd0) && (in_msg_length <= 16'(MAX_MSG_BYTES));
    assign good   = in_msg_valid && !in_msg_error && len_ok;
    assign bad    = in_msg_valid && !good;
    assign pop    = out_valid && out_ready;
    assign wr     = good && (!full || pop);
    assign drop   = good && full && !pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign out_valid = !empty;

    // Bytes beyond the message length are stored as zero so the consumer never sees stale payload.
    always_comb begin
        masked_data = '0;
        for (int i = 0; i < MAX_MSG_BYTES; i++) begin
            if (16'(i) < in_msg_length)
                masked_data[i*8 +: 8] = in_msg_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            mem_len[wr_ptr]  <= in_msg_length;
            mem_data[wr_ptr] <= masked_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop)      count <= count + 1'b1;
            else if (pop && !wr) count <= count - 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    assign out_length = out_valid ? mem_len[rd_ptr]  : 16'd0;
    assign out_data   = out_valid ? mem_data[rd_ptr] : '0;

`ifdef MSG_BUFFER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            if (bad  && err_count  != 16'hFFFF) err_count  <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_msg_buffer.sv
// Scoreboard bench for msg_buffer: a queue model of the FIFO, checked every cycle on the falling edge.
module tb_msg_buffer;
    localparam int MB    = 32;
    localparam int DEPTH = 4;
    localparam int DW    = MB * 8;

    logic          tb_clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_msg_valid = 1'b0;
    logic [15:0]   in_msg_length = '0;
    logic [DW-1:0] in_msg_data = '0;
    logic          in_msg_error = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_length;
    logic [DW-1:0] out_data;
    logic          full, empty, overflow;
`ifdef MSG_BUFFER_STATS_EN
    logic [15:0]   drop_count, err_count;
    int            exp_drop = 0, exp_err = 0;
`endif

    always #5 tb_clk = ~tb_clk;

    msg_buffer #(.MAX_MSG_BYTES(MB), .DEPTH(DEPTH)) dut (
        .clk(tb_clk), .rst(rst),
        .in_msg_valid(in_msg_valid), .in_msg_length(in_msg_length),
        .in_msg_data(in_msg_data), .in_msg_error(in_msg_error),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_length(out_length), .out_data(out_data),
        .full(full), .empty(empty), .overflow(overflow)
`ifdef MSG_BUFFER_STATS_EN
        , .drop_count(drop_count), .err_count(err_count)
`endif
    );

    typedef struct {
        logic [15:0]   len;
        logic [DW-1:0] data;
    } msg_t;

    msg_t q[$];
    logic exp_ovf = 1'b0;
    int   total = 0, bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] keep_bytes(input logic [DW-1:0] d, input logic [15:0] len);
        logic [DW-1:0] r = '0;
        for (int i = 0; i < MB; i++)
            if (i < int'(len)) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < MB / 4; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drive one cycle, check the DUT against the model before the edge, then advance the model.
    task automatic step(input logic r, input logic v, input logic e,
                        input logic [15:0] len, input logic [DW-1:0] d, input logic rdy);
        msg_t m;
        int   sz;
        logic good, popn;
        rst = r; in_msg_valid = v; in_msg_error = e;
        in_msg_length = len; in_msg_data = d; out_ready = rdy;
        @(negedge tb_clk);
        sz = q.size();
        chk("out_valid", DW'(out_valid), DW'(sz != 0));
        chk("empty", DW'(empty), DW'(sz == 0));
        chk("full", DW'(full), DW'(sz == DEPTH));
        chk("overflow", DW'(overflow), DW'(exp_ovf));
        if (sz != 0) begin
            chk("out_length", DW'(out_length), DW'(q[0].len));
            chk("out_data", out_data, q[0].data);
        end else begin
            chk("idle_length", DW'(out_length), '0);
            chk("idle_data", out_data, '0);
        end
`ifdef MSG_BUFFER_STATS_EN
        chk("drop_count", DW'(drop_count), DW'(exp_drop));
        chk("err_count", DW'(err_count), DW'(exp_err));
`endif
        if (r) begin
            q.delete();
            exp_ovf = 1'b0;
`ifdef MSG_BUFFER_STATS_EN
            exp_drop = 0; exp_err = 0;
`endif
        end else begin
            good = v && !e && len >= 16'd1 && len <= 16'(MB);
            popn = (sz != 0) && rdy;
            if (popn) void'(q.pop_front());
            if (good) begin
                if (sz < DEPTH || popn) begin
                    m.len = len; m.data = keep_bytes(d, len);
                    q.push_back(m);
                end else begin
                    exp_ovf = 1'b1;
`ifdef MSG_BUFFER_STATS_EN
                    if (exp_drop < 16'hFFFF) exp_drop++;
`endif
                end
            end
`ifdef MSG_BUFFER_STATS_EN
            else if (v && exp_err < 16'hFFFF) exp_err++;
`endif
        end
        @(posedge tb_clk);
        #1;
    endtask

    task automatic put(input logic [15:0] len, input logic rdy);
        step(1'b0, 1'b1, 1'b0, len, rnd_data(), rdy);
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0, '0, rdy);
    endtask

    initial begin
        logic [DW-1:0] ones;
        ones = '1;
        repeat (2) @(posedge tb_clk);
        #1;
        // Reset state, then the single-message latency case.
        step(1'b1, 1'b0, 1'b0, 16'd0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'd8, DW'(64'h0123456789ABCDEF), 1'b0);
        chk("first_len", DW'(out_length), DW'(16'd8));
        chk("first_data", out_data, DW'(64'h0123456789ABCDEF));
        idle(1'b1, 2);

        // Fill, drop on full, drain in order.
        put(16'd2, 1'b0); put(16'd14, 1'b0); put(16'd8, 1'b0); put(16'd4, 1'b0);
        put(16'd6, 1'b0);
        chk("ovf_sticky", DW'(overflow), DW'(1'b1));
        idle(1'b1, 5);

        // Byte masking above the length.
        step(1'b0, 1'b1, 1'b0, 16'd4, ones, 1'b0);
        chk("mask_data", out_data, DW'(32'hFFFFFFFF));
        put(16'd32, 1'b0);
        idle(1'b1, 3);

        // Silent discards: error flag, zero length, over-length.
        step(1'b1, 1'b0, 1'b0, 16'd0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'd8, rnd_data(), 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'd0, rnd_data(), 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'd33, rnd_data(), 1'b0);
        idle(1'b0, 1);

        // Pop and write in the same cycle while full, across pointer wrap.
        put(16'd1, 1'b0); put(16'd3, 1'b0); put(16'd5, 1'b0); put(16'd7, 1'b0);
        put(16'd10, 1'b1);
        for (int i = 0; i < 6; i++) put(16'(i + 11), 1'b1);
        idle(1'b1, 2);
        idle(1'b0, 1);
        put(16'd9, 1'b1);
        put(16'd12, 1'b1);
        idle(1'b1, 3);

        // Reset with a coincident write flushes everything.
        put(16'd2, 1'b0); put(16'd3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'd5, rnd_data(), 1'b0);
        idle(1'b0, 1);

        // Random traffic.
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 16'($urandom_range(0, 34)), rnd_data(), 1'($urandom_range(0, 1)));
        idle(1'b1, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
